// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and default sizing for the pipeline hazard unit.
// The scoreboard entry describes one in-flight instruction.
package pipe_hazard_unit_pkg;

  localparam int unsigned cDefXLEN       = 32;
  localparam int unsigned cDefRegAddrW   = 5;
  localparam int unsigned cDefPipeDepth  = 3;
  localparam int unsigned cDefNumRdPorts = 2;
  localparam int unsigned cDefLoadStage  = 2;
  localparam int unsigned cDefFwdSelW    = $clog2(cDefPipeDepth + 1);

  typedef logic [cDefFwdSelW-1:0] tFwdSel;

  typedef struct packed {
    logic                    vld;
    logic [cDefRegAddrW-1:0] rd;
    logic                    wr_en;
    logic                    is_load;
  } tSbEntry;

endpackage

// File: rtl/pipe_hazard_unit_port_check.sv
// Per-read-port hazard resolution: youngest matching in-flight writer wins,
// forwarded if its result exists yet, otherwise the port requests a stall.
module hazard_port_check
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned cXLEN      = cDefXLEN,
  parameter int unsigned cRegAddrW  = cDefRegAddrW,
  parameter int unsigned cPipeDepth = cDefPipeDepth,
  parameter int unsigned cLoadStage = cDefLoadStage,
  localparam int unsigned cFwdSelW  = $clog2(cPipeDepth + 1)
) (
  input  logic [cRegAddrW-1:0]        rs_addr_i,
  input  logic                        rs_used_i,
  input  logic [cXLEN-1:0]            rs_data_i,
  input  tSbEntry                     sb_i [cPipeDepth],
  input  logic [cPipeDepth*cXLEN-1:0] stage_data_i,
  output logic [cFwdSelW-1:0]         fwd_sel_o,
  output logic [cXLEN-1:0]            op_data_o,
  output logic                        stall_o
);

  logic                hit;
  logic                hit_rdy;
  logic [cFwdSelW-1:0] hit_sel;
  logic [cXLEN-1:0]    hit_data;
  logic                check;

  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_sel  = '0;
    hit_data = '0;
    // Scan oldest to youngest so the lowest matching stage overwrites older ones.
    for (int k = int'(cPipeDepth) - 1; k >= 0; k--) begin
      if (sb_i[k].vld && sb_i[k].wr_en && (sb_i[k].rd == rs_addr_i)) begin
        hit      = 1'b1;
        hit_rdy  = !sb_i[k].is_load || (k >= int'(cLoadStage));
        hit_sel  = cFwdSelW'(k + 1);
        hit_data = stage_data_i[k*cXLEN +: cXLEN];
      end
    end
  end

  assign check = rs_used_i && (rs_addr_i != '0);

  always_comb begin
    fwd_sel_o = '0;
    op_data_o = rs_data_i;
    stall_o   = 1'b0;
    if (check && hit) begin
      if (hit_rdy) begin
        fwd_sel_o = hit_sel;
        op_data_o = hit_data;
      end else begin
        stall_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard, operand forwarding and issue-stall control between decode and ALU.
// Holds the in-flight shift register and a saturating stall-cycle counter.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned cXLEN       = cDefXLEN,
  parameter int unsigned cRegAddrW   = cDefRegAddrW,
  parameter int unsigned cPipeDepth  = cDefPipeDepth,
  parameter int unsigned cNumRdPorts = cDefNumRdPorts,
  parameter int unsigned cLoadStage  = cDefLoadStage,
  localparam int unsigned cFwdSelW   = $clog2(cPipeDepth + 1)
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iIssueValid,
  output logic                            oIssueReady,
  input  logic [cNumRdPorts*cRegAddrW-1:0] iRsAddr,
  input  logic [cNumRdPorts-1:0]          iRsUsed,
  input  logic [cNumRdPorts*cXLEN-1:0]    iRsData,
  input  logic [cRegAddrW-1:0]            iRdAddr,
  input  logic                            iRdWrEn,
  input  logic                            iIsLoad,
  input  logic [cPipeDepth*cXLEN-1:0]     iStageData,
  input  logic                            iFlush,
  output logic [cNumRdPorts*cXLEN-1:0]    oOpData,
  output logic [cNumRdPorts*cFwdSelW-1:0] oFwdSel,
  output logic                            oIssueFire,
  output logic [15:0]                     oStallCnt
);

  tSbEntry                sb_q [cPipeDepth];
  tSbEntry                sb_d [cPipeDepth];
  logic [15:0]            stall_cnt_q, stall_cnt_d;
  logic [cNumRdPorts-1:0] port_stall;

  for (genvar p = 0; p < cNumRdPorts; p++) begin : g_port
    hazard_port_check #(
      .cXLEN      (cXLEN),
      .cRegAddrW  (cRegAddrW),
      .cPipeDepth (cPipeDepth),
      .cLoadStage (cLoadStage)
    ) u_chk (
      .rs_addr_i    (iRsAddr[p*cRegAddrW +: cRegAddrW]),
      .rs_used_i    (iRsUsed[p]),
      .rs_data_i    (iRsData[p*cXLEN +: cXLEN]),
      .sb_i         (sb_q),
      .stage_data_i (iStageData),
      .fwd_sel_o    (oFwdSel[p*cFwdSelW +: cFwdSelW]),
      .op_data_o    (oOpData[p*cXLEN +: cXLEN]),
      .stall_o      (port_stall[p])
    );
  end

  assign oIssueReady = !(|port_stall);
  assign oIssueFire  = iIssueValid && oIssueReady && !iFlush;
  assign oStallCnt   = stall_cnt_q;

  always_comb begin
    // A stall or flush simply loads a bubble; older entries always advance.
    sb_d[0] = '0;
    if (oIssueFire) begin
      sb_d[0].vld     = 1'b1;
      sb_d[0].rd      = iRdAddr;
      sb_d[0].wr_en   = iRdWrEn;
      sb_d[0].is_load = iIsLoad;
    end
    for (int k = 1; k < int'(cPipeDepth); k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (iIssueValid && !oIssueReady && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < int'(cPipeDepth); k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(cPipeDepth); k++) begin
        sb_q[k] <= sb_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Table-driven bench for pipe_hazard_unit: each record is one clock cycle of stimulus
// with the outputs expected in that cycle, queued on drive and checked mid-cycle.
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [9:0]  rs_addr;
  logic [1:0]  rs_used;
  logic [63:0] rs_data;
  logic [4:0]  rd_addr;
  logic        rd_wr_en;
  logic        is_load;
  logic [95:0] stage_data;
  logic        flush;
  logic [63:0] op_data;
  logic [3:0]  fwd_sel;
  logic        issue_fire;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit u_dut (
    .iClk        (clk),
    .iRst        (rst),
    .iIssueValid (issue_valid),
    .oIssueReady (issue_ready),
    .iRsAddr     (rs_addr),
    .iRsUsed     (rs_used),
    .iRsData     (rs_data),
    .iRdAddr     (rd_addr),
    .iRdWrEn     (rd_wr_en),
    .iIsLoad     (is_load),
    .iStageData  (stage_data),
    .iFlush      (flush),
    .oOpData     (op_data),
    .oFwdSel     (fwd_sel),
    .oIssueFire  (issue_fire),
    .oStallCnt   (stall_cnt)
  );

  typedef struct {
    logic        rst, valid;
    logic [4:0]  rs0, rs1;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        wr, ld, flush;
    logic        e_ready, e_fire;
    logic [1:0]  e_fwd0, e_fwd1;
    logic [1:0]  chk_fwd;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ready, fire;
    logic [1:0]  fwd0, fwd1;
    logic [1:0]  chk_fwd;
    logic [31:0] op0, op1;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[14];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic v, logic [4:0] a0, logic [4:0] a1, logic [1:0] u,
                              logic [4:0] d, logic w, logic l, logic f, logic er, logic ef,
                              logic [1:0] f0, logic [1:0] f1, logic [1:0] cm, logic [15:0] c);
    vec_t t;
    t.rst = r; t.valid = v; t.rs0 = a0; t.rs1 = a1; t.used = u; t.rd = d;
    t.wr = w; t.ld = l; t.flush = f; t.e_ready = er; t.e_fire = ef;
    t.e_fwd0 = f0; t.e_fwd1 = f1; t.chk_fwd = cm; t.e_cnt = c;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @vec%0d: got %h required %h", nm, idx, act, req);
    end
  endtask

  function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] rf, logic [95:0] sd);
    logic [31:0] r;
    case (sel)
      2'd0:    r = rf;
      2'd1:    r = sd[31:0];
      2'd2:    r = sd[63:32];
      default: r = sd[95:64];
    endcase
    return r;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    rst         = v.rst;
    issue_valid = v.valid;
    rs_addr     = {v.rs1, v.rs0};
    rs_used     = v.used;
    rd_addr     = v.rd;
    rd_wr_en    = v.wr;
    is_load     = v.ld;
    flush       = v.flush;
    rs_data     = {32'hB000_0000 + idx, 32'hA000_0000 + idx};
    stage_data  = {32'h2222_0000 + idx, 32'h1111_0000 + idx, 32'hDEAD_BEEF};
    e.idx     = idx;
    e.ready   = v.e_ready;
    e.fire    = v.e_fire;
    e.fwd0    = v.e_fwd0;
    e.fwd1    = v.e_fwd1;
    e.chk_fwd = v.chk_fwd;
    e.op0     = pick(v.e_fwd0, rs_data[31:0], stage_data);
    e.op1     = pick(v.e_fwd1, rs_data[63:32], stage_data);
    e.cnt     = v.e_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    chk("issue_ready", g.idx, {31'b0, issue_ready}, {31'b0, g.ready});
    chk("issue_fire", g.idx, {31'b0, issue_fire}, {31'b0, g.fire});
    chk("stall_cnt", g.idx, {16'b0, stall_cnt}, {16'b0, g.cnt});
    if (g.chk_fwd[0]) begin
      chk("fwd_sel0", g.idx, {30'b0, fwd_sel[1:0]}, {30'b0, g.fwd0});
      chk("op_data0", g.idx, op_data[31:0], g.op0);
    end
    if (g.chk_fwd[1]) begin
      chk("fwd_sel1", g.idx, {30'b0, fwd_sel[3:2]}, {30'b0, g.fwd1});
      chk("op_data1", g.idx, op_data[63:32], g.op1);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; rs_addr = '0; rs_used = '0; rs_data = '0;
    rd_addr = '0; rd_wr_en = 1'b0; is_load = 1'b0; stage_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);

    //              rst v  rs0 rs1 used   rd wr ld fl  rdy fire f0 f1 chk   cnt
    tbl[0]  = mk(1, 1, 1,  2,  2'b11, 3,  1, 0, 0, 1,  1,   0, 0, 2'b11, 0);
    tbl[1]  = mk(0, 1, 1,  2,  2'b11, 3,  1, 0, 0, 1,  1,   0, 0, 2'b11, 0);
    tbl[2]  = mk(0, 1, 6,  7,  2'b11, 5,  1, 0, 0, 1,  1,   0, 0, 2'b11, 0);
    tbl[3]  = mk(0, 1, 5,  3,  2'b11, 8,  1, 0, 0, 1,  1,   1, 2, 2'b11, 0);
    tbl[4]  = mk(0, 1, 3,  5,  2'b11, 7,  1, 1, 0, 1,  1,   3, 2, 2'b11, 0);
    tbl[5]  = mk(0, 1, 7,  8,  2'b11, 10, 1, 0, 0, 0,  0,   0, 2, 2'b10, 0);
    tbl[6]  = mk(0, 1, 7,  8,  2'b11, 10, 1, 0, 0, 0,  0,   0, 3, 2'b10, 1);
    tbl[7]  = mk(0, 1, 7,  8,  2'b11, 10, 1, 0, 0, 1,  1,   3, 0, 2'b11, 2);
    tbl[8]  = mk(0, 1, 0,  0,  2'b00, 9,  1, 0, 0, 1,  1,   0, 0, 2'b11, 2);
    tbl[9]  = mk(0, 1, 0,  0,  2'b00, 9,  1, 0, 0, 1,  1,   0, 0, 2'b11, 2);
    tbl[10] = mk(0, 1, 9,  10, 2'b11, 0,  1, 0, 0, 1,  1,   1, 3, 2'b11, 2);
    tbl[11] = mk(0, 1, 0,  9,  2'b11, 4,  0, 0, 0, 1,  1,   0, 2, 2'b11, 2);
    tbl[12] = mk(0, 1, 4,  9,  2'b01, 0,  0, 0, 0, 1,  1,   0, 0, 2'b11, 2);
    tbl[13] = mk(0, 0, 0,  0,  2'b00, 0,  0, 0, 0, 1,  0,   0, 0, 2'b11, 2);

    for (int i = 0; i < 14; i++) apply(tbl[i], i);

    // Flush of an otherwise-ready issue: nothing enters stage 0.
    apply(mk(0, 1, 0,  0, 2'b00, 13, 1, 0, 1, 1, 0, 0, 0, 2'b11, 2), 14);
    apply(mk(0, 1, 13, 0, 2'b01, 12, 1, 1, 0, 1, 1, 0, 0, 2'b11, 2), 15);
    // Flush during a load-use stall, then reset while still stalled.
    apply(mk(0, 1, 12, 0, 2'b01, 14, 1, 0, 1, 0, 0, 0, 0, 2'b10, 2), 16);
    apply(mk(1, 1, 12, 0, 2'b01, 14, 1, 0, 0, 0, 0, 0, 0, 2'b10, 3), 17);
    apply(mk(0, 1, 12, 0, 2'b01, 14, 1, 0, 0, 1, 1, 0, 0, 2'b11, 0), 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
